// File: rtl/mux_share_arb_pkg.sv
// Shared constants for the two-requester shared-mux arbiter: state codes and
// default parameter values.
package mux_share_arb_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_MAX_HOLD = 4;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE = 2'd0;
  localparam arb_state_t ST_OWN0 = 2'd1;
  localparam arb_state_t ST_OWN1 = 2'd2;

endpackage

// File: rtl/mux_share_arb_mux2_w.sv
// WIDTH-bit 2:1 data mux; sel=0 routes the first input.
module mux2_w
  import mux_share_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux_share_arb.sv
// Two-requester arbiter sharing one output register; an owner keeps the mux
// for at most MAX_HOLD accepted beats while the other side is waiting.
//
// state | meaning
// IDLE  | no owner; arbitrate this cycle, nothing accepted
// OWN0  | requester 0 owns the mux (gnt0)
// OWN1  | requester 1 owns the mux (gnt1)
module mux_share_arb
  import mux_share_arb_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  arb_state_t       state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic             last, last_nxt;
  logic             load, accept0, accept1;
  logic [WIDTH-1:0] mux_y;

  assign gnt0    = (state == ST_OWN0);
  assign gnt1    = (state == ST_OWN1);
  assign sel     = gnt1;
  assign load    = !out_valid || out_ready;
  assign accept0 = gnt0 && req0 && load;
  assign accept1 = gnt1 && req1 && load;

  mux2_w #(.WIDTH(WIDTH)) u_mux (
    .sel (sel),
    .a   (d0),
    .b   (d1),
    .y   (mux_y)
  );

  // A dropped request is checked before the hold limit, so losing both
  // requesters during a forced switch falls back to IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    case (state)
      ST_IDLE: begin
        if (req0 && req1)  state_nxt = last ? ST_OWN0 : ST_OWN1;
        else if (req0)     state_nxt = ST_OWN0;
        else if (req1)     state_nxt = ST_OWN1;
      end
      ST_OWN0: begin
        if (!req0) begin
          state_nxt = req1 ? ST_OWN1 : ST_IDLE;
          last_nxt  = 1'b0;
        end else if (accept0 && (cnt == HOLD_LAST) && req1) begin
          state_nxt = ST_OWN1;
          last_nxt  = 1'b0;
        end else if (accept0 && (cnt != HOLD_LAST)) begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      ST_OWN1: begin
        if (!req1) begin
          state_nxt = req0 ? ST_OWN0 : ST_IDLE;
          last_nxt  = 1'b1;
        end else if (accept1 && (cnt == HOLD_LAST) && req0) begin
          state_nxt = ST_OWN0;
          last_nxt  = 1'b1;
        end else if (accept1 && (cnt != HOLD_LAST)) begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (state_nxt != state) cnt_nxt = 4'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= accept0 || accept1;
      if (accept0 || accept1) out_data <= mux_y;
    end
  end

endmodule

// File: tb/tb_mux_share_arb.sv
// Self-checking bench for mux_share_arb: directed scenarios plus a randomized
// run compared cycle by cycle against a behavioural owner/streak model.
module tb_mux_share_arb;

  localparam int W  = 32;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0, out_ready = 1'b0;
  logic [W-1:0] d0 = '0, d1 = '0;
  logic         gnt0, gnt1, sel, out_valid;
  logic [W-1:0] out_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_share_arb #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .d0        (d0),
    .d1        (d1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  // Reference model: owner is -1 (nobody), 0 or 1; streak counts beats taken
  // by the current owner in a row; prev_owner remembers who last gave up.
  int           m_owner = -1;
  int           m_streak = 0;
  int           m_prev = 1;
  logic         m_valid = 1'b0;
  logic [W-1:0] m_data = '0;
  bit           m_acc = 1'b0;
  int           m_acc_who = -1;
  bit   [1:0]   mr;
  logic [W-1:0] md [2];
  bit           m_ld;
  int           m_new;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_streak = 0; m_prev = 1;
      m_valid = 1'b0; m_data = '0; m_acc = 1'b0; m_acc_who = -1;
    end else begin
      mr[0] = req0; mr[1] = req1; md[0] = d0; md[1] = d1;
      m_ld = !m_valid || out_ready;
      m_acc = 1'b0;
      if (m_owner >= 0) m_acc = mr[m_owner[0]] && m_ld;
      m_acc_who = m_acc ? m_owner : -1;
      if (m_ld) begin
        m_valid = m_acc;
        if (m_acc) m_data = md[m_owner[0]];
      end
      m_new = m_owner;
      if (m_owner < 0) begin
        if (mr[0] && mr[1]) m_new = 1 - m_prev;
        else if (mr[0])     m_new = 0;
        else if (mr[1])     m_new = 1;
      end else if (!mr[m_owner[0]]) begin
        m_new  = mr[1 - m_owner] ? 1 - m_owner : -1;
        m_prev = m_owner;
      end else if (m_acc && m_streak + 1 >= MH && mr[1 - m_owner]) begin
        m_new  = 1 - m_owner;
        m_prev = m_owner;
      end else if (m_acc && m_streak + 1 < MH) begin
        m_streak = m_streak + 1;
      end
      if (m_new != m_owner) m_streak = 0;
      m_owner = m_new;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; out_ready = 1'b1;
    d0 = 32'h1111_1111; d1 = 32'h2222_2222;
    repeat (3) @(negedge clk);
    n_cmp++; if (gnt0 !== 1'b0) begin n_err++; $display("FAIL reset_gnt0 got %b want 0", gnt0); end
    n_cmp++; if (gnt1 !== 1'b0) begin n_err++; $display("FAIL reset_gnt1 got %b want 0", gnt1); end
    n_cmp++; if (sel !== 1'b0) begin n_err++; $display("FAIL reset_sel got %b want 0", sel); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_data got %h want 0", out_data); end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_single_beat();
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b0; d0 = 32'hA5A5_A5A5; out_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (gnt0 !== 1'b1) begin n_err++; $display("FAIL single_gnt0_c1 got %b want 1", gnt0); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_c1 got %b want 0", out_valid); end
    @(negedge clk);
    req0 = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid_c2 got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL single_data_c2 got %h want a5a5a5a5", out_data); end
  endtask

  task automatic test_alternate();
    int got = 0;
    int k0 = 0, k1 = 0;
    logic [W-1:0] exp;
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; out_ready = 1'b1;
    d0 = 32'h0000_0000; d1 = 32'h1000_0000;
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 60 && got < 16; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (((got / MH) % 2) == 0) begin exp = 32'h0000_0000 + W'(k0); k0++; end
        else begin exp = 32'h1000_0000 + W'(k1); k1++; end
        n_cmp++;
        if (out_data !== exp) begin
          n_err++; $display("FAIL alt_beat%0d got %h want %h", got, out_data, exp);
        end
        got++;
      end
      if (m_acc && m_acc_who == 0) d0 = d0 + 1;
      if (m_acc && m_acc_who == 1) d1 = d1 + 1;
    end
    n_cmp++; if (got != 16) begin n_err++; $display("FAIL alt_count got %0d want 16", got); end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_stall();
    logic [W-1:0] expect_next = 32'd100;
    logic [W-1:0] held = '0;
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b1; d1 = 32'd100; out_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      out_ready = !(c >= 6 && c <= 8);
      if (c == 6) held = out_data;
      if (c >= 6 && c <= 8) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          n_err++; $display("FAIL stall_frozen c%0d got %b/%h want 1/%h", c, out_valid, out_data, held);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_cmp++;
        if (out_data !== expect_next) begin
          n_err++; $display("FAIL stall_seq got %h want %h", out_data, expect_next);
        end
        expect_next = expect_next + 1;
      end
      if (m_acc && m_acc_who == 1) d1 = d1 + 1;
    end
    n_cmp++; if (expect_next < 32'd110) begin n_err++; $display("FAIL stall_count got %0d want >=10", expect_next - 100); end
    req1 = 1'b0;
  endtask

  task automatic test_drop_switch();
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b0; out_ready = 1'b1; d0 = 32'h7; d1 = 32'h9;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (gnt0 !== 1'b1) begin n_err++; $display("FAIL drop_own0 got %b want 1", gnt0); end
    req0 = 1'b0; req1 = 1'b1;
    @(negedge clk);
    n_cmp++; if (gnt1 !== 1'b1) begin n_err++; $display("FAIL drop_gnt1 got %b want 1", gnt1); end
    n_cmp++; if (gnt0 !== 1'b0) begin n_err++; $display("FAIL drop_gnt0 got %b want 0", gnt0); end
    req1 = 1'b0;
  endtask

  task automatic test_async_reset();
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b0; out_ready = 1'b1; d0 = 32'h5A;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL arst_pre_valid got %b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got %b want 0", out_valid); end
    n_cmp++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin n_err++; $display("FAIL arst_gnt got %b%b want 00", gnt1, gnt0); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL arst_data got %h want 0", out_data); end
    req0 = 1'b1; req1 = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin n_err++; $display("FAIL arst_first_tie got %b%b want 01", gnt1, gnt0); end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_random();
    bit   [1:0]   rq = 2'b00;
    logic [W-1:0] dd [2];
    bit           was_acc;
    dd[0] = '0; dd[1] = '0;
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; out_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      n_cmp++; if (gnt0 !== (m_owner == 0)) begin n_err++; $display("FAIL rand_gnt0 c%0d got %b want %b", c, gnt0, m_owner == 0); end
      n_cmp++; if (gnt1 !== (m_owner == 1)) begin n_err++; $display("FAIL rand_gnt1 c%0d got %b want %b", c, gnt1, m_owner == 1); end
      n_cmp++; if (sel !== (m_owner == 1) || sel !== gnt1) begin n_err++; $display("FAIL rand_sel c%0d got %b want %b", c, sel, m_owner == 1); end
      n_cmp++; if ((gnt0 & gnt1) !== 1'b0) begin n_err++; $display("FAIL rand_onehot c%0d got %b%b want not 11", c, gnt1, gnt0); end
      n_cmp++; if (out_valid !== m_valid) begin n_err++; $display("FAIL rand_valid c%0d got %b want %b", c, out_valid, m_valid); end
      n_cmp++; if (out_data !== m_data) begin n_err++; $display("FAIL rand_data c%0d got %h want %h", c, out_data, m_data); end
      for (int k = 0; k < 2; k++) begin
        was_acc = m_acc && (m_acc_who == k);
        if (was_acc) begin
          rq[k] = ($urandom_range(0, 3) != 0); dd[k] = $urandom;
        end else if (!rq[k]) begin
          rq[k] = ($urandom_range(0, 2) == 0); dd[k] = $urandom;
        end else if ($urandom_range(0, 19) == 0) begin
          rq[k] = 1'b0;
        end
      end
      req0 = rq[0]; req1 = rq[1]; d0 = dd[0]; d1 = dd[1];
      out_ready = ($urandom_range(0, 3) != 0);
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_beat();
    test_alternate();
    test_stall();
    test_drop_switch();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
